// File: rtl/phase_sequencer.sv
// Purpose      : one-hot IF/DE/EX/WB phase generator with run/step/stop, wait states and PC breakpoint
// Latency      : one cycle per phase; IF, and WB when wb_mem=1, extend while mem_ready is low
// Backpressure : mem_ready low holds the phase with stall=1; WAIT_MAX waits in one phase abort to IDLE
//
// Sits between the debug/console front end and the KAPPA3 controller. cstate is
// the registered phase itself (IF=0001, DE=0010, EX=0100, WB=1000, IDLE=0000),
// so the controller sees glitch-free phase enables.
//
// Parameters:
//   WAIT_MAX  wait cycles tolerated in one memory phase before timeout (>=1)
//   WAIT_W    width of the wait counter; must be able to hold WAIT_MAX
//   COUNT_W   width of the retired-instruction counter
//
// Ports:
//   clock        in   rising-edge system clock
//   reset        in   asynchronous active-high reset
//   run          in   pulse: start continuous execution from IDLE
//   step         in   pulse: execute exactly one instruction from IDLE
//   stop         in   request halt at the next instruction boundary
//   wb_mem       in   controller has a load/store in WB
//   mem_ready    in   memory completed the current access this cycle
//   pc           in   current PC register value
//   bp_en        in   breakpoint enable
//   bp_addr      in   breakpoint PC
//   cstate       out  one-hot phase, 0000 = IDLE
//   stall        out  memory phase waiting; the top gates every register load with ~stall
//   running      out  cstate != IDLE
//   halt_cause   out  00 stop, 01 step done, 10 breakpoint, 11 memory timeout
//   instr_count  out  retired instruction count
//
// Build option KAPPA3_INSTR_COUNT_EN: when defined, instr_count is a free-running
// COUNT_W counter of retired instructions (wraps, cleared only by reset). When
// undefined, instr_count is tied to zero and no counter flops exist.

module phase_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4,
    parameter int COUNT_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               stop,
    input  logic               wb_mem,
    input  logic               mem_ready,
    input  logic [31:0]        pc,
    input  logic               bp_en,
    input  logic [31:0]        bp_addr,
    output logic [3:0]         cstate,
    output logic               stall,
    output logic               running,
    output logic [1:0]         halt_cause,
    output logic [COUNT_W-1:0] instr_count
);

    // The encoding is the one-hot phase vector the controller consumes, so the
    // state register drives cstate directly with no output decode.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0000,
        S_IF   = 4'b0001,
        S_DE   = 4'b0010,
        S_EX   = 4'b0100,
        S_WB   = 4'b1000
    } phase_t;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_STEP = 2'd2
    } mode_t;

    localparam logic [1:0] CAUSE_STOP    = 2'b00;
    localparam logic [1:0] CAUSE_STEP    = 2'b01;
    localparam logic [1:0] CAUSE_BREAK   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // The counter holds the number of wait cycles already spent in this phase.
    // When it shows WAIT_MAX-1 and memory is still not ready, the current cycle
    // is wait number WAIT_MAX and the phase is abandoned.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    phase_t             phase_q;
    mode_t              mode_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic               stop_q;       // stop seen since this instruction began

    logic               mem_phase;
    logic               timeout;
    logic               stop_seen;
    logic               bp_hit;

    // ------------------------------------------------------------------
    // Combinational status
    // ------------------------------------------------------------------

    // IF always touches memory; WB only for loads/stores.
    assign mem_phase = (phase_q == S_IF) || ((phase_q == S_WB) && wb_mem);

    // stall must respond in the same cycle mem_ready drops, otherwise the
    // controller would load a register with data that has not arrived.
    assign stall     = mem_phase && !mem_ready;

    // mem_ready=1 in the final allowed cycle still completes the access,
    // because stall is then low.
    assign timeout   = stall && (wait_cnt_q == WAIT_LAST);

    // A stop arriving in the retiring WB cycle itself counts as seen.
    assign stop_seen = stop_q || stop;

    // pc already holds the address of the next instruction during WB, so a
    // match here halts before that instruction is fetched.
    assign bp_hit    = bp_en && (pc == bp_addr);

    assign cstate    = phase_q;
    assign running   = (phase_q != S_IDLE);

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q    <= S_IDLE;
            mode_q     <= MODE_NONE;
            wait_cnt_q <= '0;
            stop_q     <= 1'b0;
            halt_cause <= CAUSE_STOP;
        end else begin
            case (phase_q)
                S_IDLE: begin
                    // run and step while idle start execution; run wins a tie.
                    // A simultaneous stop vetoes the start and reports a stop
                    // halt. stop alone in IDLE is ignored and never latched.
                    if (run || step) begin
                        if (stop) begin
                            halt_cause <= CAUSE_STOP;
                        end else begin
                            phase_q <= S_IF;
                            mode_q  <= run ? MODE_RUN : MODE_STEP;
                        end
                    end
                end

                default: begin
                    // run/step are ignored while running; stop is latched and
                    // acted upon at the next instruction boundary.
                    if (stop) begin
                        stop_q <= 1'b1;
                    end

                    if (timeout) begin
                        // Abandon the instruction: nothing retires.
                        phase_q    <= S_IDLE;
                        mode_q     <= MODE_NONE;
                        wait_cnt_q <= '0;
                        stop_q     <= 1'b0;
                        halt_cause <= CAUSE_TIMEOUT;
                    end else if (stall) begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end else begin
                        wait_cnt_q <= '0;
                        case (phase_q)
                            S_IF: phase_q <= S_DE;
                            S_DE: phase_q <= S_EX;
                            S_EX: phase_q <= S_WB;
                            default: begin
                                // WB retiring: decide whether to fetch the
                                // next instruction or halt, highest priority
                                // first.
                                if (stop_seen) begin
                                    phase_q    <= S_IDLE;
                                    mode_q     <= MODE_NONE;
                                    stop_q     <= 1'b0;
                                    halt_cause <= CAUSE_STOP;
                                end else if (mode_q == MODE_STEP) begin
                                    phase_q    <= S_IDLE;
                                    mode_q     <= MODE_NONE;
                                    stop_q     <= 1'b0;
                                    halt_cause <= CAUSE_STEP;
                                end else if (bp_hit) begin
                                    phase_q    <= S_IDLE;
                                    mode_q     <= MODE_NONE;
                                    stop_q     <= 1'b0;
                                    halt_cause <= CAUSE_BREAK;
                                end else begin
                                    phase_q <= S_IF;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
`ifdef KAPPA3_INSTR_COUNT_EN
    logic               retire;
    logic [COUNT_W-1:0] count_q;

    // An instruction retires when WB completes without waiting; a timed-out
    // WB never reaches this condition.
    assign retire = (phase_q == S_WB) && !stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Purpose      : self-checking bench for phase_sequencer with a phase-level reference model
// Latency      : expected outputs are queued per cycle and checked one half-cycle later
// Backpressure : mem_ready is randomly dropped, including long stuck-low bursts

module tb_phase_sequencer;

    localparam int WAIT_MAX = 15;
    localparam int WAIT_W   = 4;
    localparam int COUNT_W  = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic               run;
    logic               step;
    logic               stop;
    logic               wb_mem;
    logic               mem_ready;
    logic [31:0]        pc;
    logic               bp_en;
    logic [31:0]        bp_addr;
    logic [3:0]         cstate;
    logic               stall;
    logic               running;
    logic [1:0]         halt_cause;
    logic [COUNT_W-1:0] instr_count;

    phase_sequencer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .stop        (stop),
        .wb_mem      (wb_mem),
        .mem_ready   (mem_ready),
        .pc          (pc),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cstate      (cstate),
        .stall       (stall),
        .running     (running),
        .halt_cause  (halt_cause),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]         cstate;
        logic               stall;
        logic               running;
        logic [1:0]         cause;
        logic [COUNT_W-1:0] count;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: instruction position as a small integer
    // (0 idle, 1 fetch, 2 decode, 3 execute, 4 write-back).
    int           m_phase;
    bit           m_step_mode;
    bit           m_stop_lat;
    int           m_waits;
    int           m_cause;
    longint       m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic go_idle(input int cause);
        m_phase    = 0;
        m_cause    = cause;
        m_stop_lat = 0;
        m_waits    = 0;
    endtask

    // Called just after a rising edge with this cycle's inputs already driven:
    // queues the expected outputs for this cycle, advances the model across
    // the next rising edge, and moves the simulated PC past fetched words.
    task automatic tick();
        obs_t e;
        bit   mem;
        bit   waiting;
        bit   fetched;
        if (reset) begin
            m_phase     = 0;
            m_step_mode = 0;
            m_stop_lat  = 0;
            m_waits     = 0;
            m_cause     = 0;
            m_count     = 0;
        end
        mem     = (m_phase == 1) || (m_phase == 4 && wb_mem);
        waiting = mem && !mem_ready;
        fetched = 0;

        e.cstate  = (m_phase == 0) ? 4'b0000 : 4'(1 << (m_phase - 1));
        e.stall   = waiting;
        e.running = (m_phase != 0);
        e.cause   = 2'(m_cause);
`ifdef KAPPA3_INSTR_COUNT_EN
        e.count   = COUNT_W'(m_count);
`else
        e.count   = '0;
`endif
        exp_q.push_back(e);

        if (!reset) begin
            if (m_phase == 0) begin
                if (run || step) begin
                    if (stop) m_cause = 0;
                    else begin
                        m_phase     = 1;
                        m_step_mode = !run;
                    end
                end
            end else begin
                if (stop) m_stop_lat = 1;
                if (waiting) begin
                    m_waits++;
                    if (m_waits == WAIT_MAX) go_idle(3);
                end else begin
                    m_waits = 0;
                    if (m_phase == 4) begin
                        m_count++;
                        if (m_stop_lat)                  go_idle(0);
                        else if (m_step_mode)            go_idle(1);
                        else if (bp_en && pc == bp_addr) go_idle(2);
                        else                             m_phase = 1;
                    end else begin
                        if (m_phase == 1) fetched = 1;
                        m_phase++;
                    end
                end
            end
        end

        @(posedge clock);
        #1;
        if (fetched) pc = pc + 32'd4;
    endtask

    task automatic clear_ctl();
        run  = 0;
        step = 0;
        stop = 0;
    endtask

    task automatic run_until_phase(input logic [3:0] ph, input int budget);
        int n = 0;
        while (cstate !== ph && n < budget) begin
            n++;
            tick();
        end
        check("reach_phase", 32'(cstate), 32'(ph));
    endtask

    task automatic run_until_idle(input int budget, output int n);
        n = 0;
        while (running && n < budget) begin
            n++;
            tick();
        end
        check("reach_idle", 32'(running), 32'd0);
    endtask

    // Monitor: compares the DUT against the queued expectation on every
    // falling edge, away from the edge that updates the DUT.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {cstate, stall, running, halt_cause, instr_count};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_obs t=%0t: got cstate=%b stall=%b running=%b cause=%b count=%0d, expected cstate=%b stall=%b running=%b cause=%b count=%0d",
                             $time, a.cstate, a.stall, a.running, a.cause, a.count,
                             e.cstate, e.stall, e.running, e.cause, e.count);
                end
            end
        end
    end

    initial begin
        int n;
        int stuck;
        reset = 1; run = 0; step = 0; stop = 0; wb_mem = 0; mem_ready = 1;
        bp_en = 0; bp_addr = 0; pc = 0;
        m_phase = 0; m_step_mode = 0; m_stop_lat = 0; m_waits = 0; m_cause = 0; m_count = 0;

        @(posedge clock);
        #1;
        tick();
        tick();
        check("reset_cstate", 32'(cstate), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_cause", 32'(halt_cause), 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);
        reset = 0;

        // Continuous run: phases repeat IF..WB.
        run = 1; tick(); clear_ctl();
        check("run_enters_if", 32'(cstate), 32'h1);
        repeat (8) tick();
        check("run_wraps_to_if", 32'(cstate), 32'h1);
        check("run_running", 32'(running), 32'd1);
        stop = 1; tick(); clear_ctl();
        run_until_idle(10, n);
        check("run_stop_cause", 32'(halt_cause), 32'd0);

        // stop while idle is not latched; a step then runs exactly 4 phases.
        stop = 1; tick(); clear_ctl();
        step = 1; tick(); clear_ctl();
        run_until_idle(20, n);
        check("step_phases", 32'(n), 32'd4);
        check("step_cause", 32'(halt_cause), 32'd1);

        // run and stop together while idle: stay idle, cause becomes stop.
        run = 1; stop = 1; tick(); clear_ctl();
        check("run_stop_same_running", 32'(running), 32'd0);
        check("run_stop_same_cause", 32'(halt_cause), 32'd0);

        // run and step together: run wins, so execution continues.
        run = 1; step = 1; tick(); clear_ctl();
        repeat (8) tick();
        check("run_beats_step", 32'(running), 32'd1);
        stop = 1; tick(); clear_ctl();
        run_until_idle(10, n);

        // Fetch waits three cycles, then advances to decode.
        step = 1; tick(); clear_ctl();
        mem_ready = 0;
        repeat (3) tick();
        check("if_hold", 32'(cstate), 32'h1);
        mem_ready = 1;
        tick();
        check("if_release", 32'(cstate), 32'h2);
        run_until_idle(10, n);
        check("wait_step_cause", 32'(halt_cause), 32'd1);

        // Write-back memory never ready: timeout after WAIT_MAX stall cycles.
        wb_mem = 1;
        step = 1; tick(); clear_ctl();
        run_until_phase(4'b1000, 10);
        mem_ready = 0;
        n = 0;
        while (running && n < 40) begin
            n++;
            tick();
        end
        check("timeout_cycles", 32'(n), 32'(WAIT_MAX));
        check("timeout_cause", 32'(halt_cause), 32'd3);
        mem_ready = 1;
        wb_mem = 0;

        // stop during EX: WB still completes, then idle with stop cause.
        run = 1; tick(); clear_ctl();
        run_until_phase(4'b0100, 10);
        stop = 1; tick(); clear_ctl();
        check("stop_wb_completes", 32'(cstate), 32'h8);
        tick();
        check("stop_ex_idle", 32'(running), 32'd0);
        check("stop_ex_cause", 32'(halt_cause), 32'd0);

        // Reset asserted in DE clears cstate without waiting for a clock.
        run = 1; tick(); clear_ctl();
        tick();
        check("reach_de", 32'(cstate), 32'h2);
        reset = 1;
        #1;
        check("async_reset_cstate", 32'(cstate), 32'd0);
        tick();
        reset = 0;

        // Breakpoint at 0x10 on straight-line code from 0.
        pc = 0; bp_en = 1; bp_addr = 32'h10;
        run = 1; tick(); clear_ctl();
        run_until_idle(60, n);
        check("bp_cycles", 32'(n), 32'd16);
        check("bp_cause", 32'(halt_cause), 32'd2);
        run = 1; tick(); clear_ctl();
        repeat (8) tick();
        check("bp_resume_runs", 32'(running), 32'd1);
        bp_en = 0;
        stop = 1; tick(); clear_ctl();
        run_until_idle(10, n);

        // Randomized traffic.
        stuck = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            run   = ($urandom_range(0, 15) == 0);
            step  = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            wb_mem = 1'($urandom_range(0, 1));
            if (stuck == 0 && $urandom_range(0, 79) == 0) stuck = $urandom_range(10, 20);
            if (stuck > 0) begin
                mem_ready = 0;
                stuck--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 49) == 0) begin
                bp_en   = 1'($urandom_range(0, 1));
                bp_addr = 32'($urandom_range(1, 12)) << 2;
            end
            if (m_phase == 0 && pc > 32'h40) pc = 0;
            tick();
        end

        reset = 0; clear_ctl(); mem_ready = 1;
        repeat (3) tick();
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
